// File: rtl/serial_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator, MSB-first, one bit per clock.
// Unsigned or two's-complement compare, with optional early exit on the first differing bit.
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             smaller,
    output logic             equal,
    output logic             greater
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // One-bit decision, returned as {lt, gt}; at the signed MSB a 1 marks the smaller operand.
    function automatic logic [1:0] bit_decide(input logic a_bit, input logic b_bit, input logic sign_bit);
        logic [1:0] dec;
        if (a_bit == b_bit) begin
            dec = 2'b00;
        end else if (sign_bit) begin
            dec = a_bit ? 2'b10 : 2'b01;
        end else begin
            dec = a_bit ? 2'b01 : 2'b10;
        end
        return dec;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_a, r_b, w_a_nxt, w_b_nxt;
    logic              r_signed, w_signed_nxt;
    logic [IW-1:0]     r_idx, w_idx_nxt;
    logic              r_lt, r_gt, w_lt_nxt, w_gt_nxt;
    logic              r_busy, r_done, r_smaller, r_equal, r_greater;
    logic              w_busy_nxt, w_done_nxt, w_smaller_nxt, w_equal_nxt, w_greater_nxt;
    logic [1:0]        w_dec;
    logic              w_lt, w_gt, w_last;

    // Running decision: the first differing bit fixes the result for the remaining steps.
    always_comb begin
        w_dec  = bit_decide(r_a[r_idx], r_b[r_idx], r_signed && (r_idx == IW'(WIDTH-1)));
        w_lt   = r_lt | (~r_lt & ~r_gt & w_dec[1]);
        w_gt   = r_gt | (~r_lt & ~r_gt & w_dec[0]);
        w_last = (r_idx == '0) || (EARLY_EXIT && (w_lt || w_gt));
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_signed_nxt  = r_signed;
        w_idx_nxt     = r_idx;
        w_lt_nxt      = r_lt;
        w_gt_nxt      = r_gt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_smaller_nxt = r_smaller;
        w_equal_nxt   = r_equal;
        w_greater_nxt = r_greater;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_signed_nxt = signed_mode;
                    w_idx_nxt    = IW'(WIDTH-1);
                    w_lt_nxt     = 1'b0;
                    w_gt_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_SHIFT;
                end else begin
                    w_busy_nxt   = 1'b0;
                end
            end
            ST_SHIFT: begin
                w_lt_nxt = w_lt;
                w_gt_nxt = w_gt;
                if (w_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_smaller_nxt = w_lt;
                    w_greater_nxt = w_gt;
                    w_equal_nxt   = ~(w_lt | w_gt);
                end else begin
                    w_idx_nxt     = r_idx - IW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_idx     <= '0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_smaller <= 1'b0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_signed  <= w_signed_nxt;
            r_idx     <= w_idx_nxt;
            r_lt      <= w_lt_nxt;
            r_gt      <= w_gt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_smaller <= w_smaller_nxt;
            r_equal   <= w_equal_nxt;
            r_greater <= w_greater_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign smaller = r_smaller;
    assign equal   = r_equal;
    assign greater = r_greater;
endmodule
